// File: rtl/seq_gen_pkg.sv
// Shared state encoding and length helper for the sequence_gen serial transmitter.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } seq_state_e;

  // Zero or over-long requests fall back to the full register width.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if ((len == 32'd0) || (len > max_len)) begin
      return max_len;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/seq_gen_shreg.sv
// Loadable left shift register with a bit down-counter; msb is the bit on the line,
// last flags the final bit of the frame.
module seq_gen_shreg
  import seq_gen_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] load_data,
  input  logic [LEN_W-1:0]   load_len,
  output logic               msb,
  output logic               last,
  output logic [LEN_W-1:0]   count
);

  logic [MAX_LEN-1:0] r_data;
  logic [LEN_W-1:0]   r_cnt;

  // Load wins over shift; zeros fill from the right so msb idles low once drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= {MAX_LEN{1'b0}};
      r_cnt  <= {LEN_W{1'b0}};
    end else if (load) begin
      r_data <= load_data;
      r_cnt  <= load_len;
    end else if (shift) begin
      r_data <= {r_data[MAX_LEN-2:0], 1'b0};
      r_cnt  <= (r_cnt == {LEN_W{1'b0}}) ? r_cnt : (r_cnt - LEN_W'(1));
    end else begin
      r_data <= r_data;
      r_cnt  <= r_cnt;
    end
  end

  assign msb   = r_data[MAX_LEN-1];
  assign last  = (r_cnt == LEN_W'(1));
  assign count = r_cnt;

endmodule

// File: rtl/sequence_gen.sv
// Serial pattern transmitter: parallel pattern in over valid/ready, MSB-first bit stream out.
// Define SEQ_GEN_REPEAT_EN to add rep_en and frame replay from a shadow copy.
module sequence_gen
  import seq_gen_pkg::*;
#(
  parameter  int MAX_LEN = 8,
  parameter  int GAP     = 0,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MAX_LEN-1:0] pat_data,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               pat_valid,
  output logic               pat_ready,
  output logic               out,
  output logic               out_valid,
  output logic               done,
  output logic               busy
`ifdef SEQ_GEN_REPEAT_EN
  ,
  input  logic               rep_en
`endif
);

  localparam int                 GAP_W    = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'((GAP > 0) ? (GAP - 1) : 0);
  localparam bit                 HAS_GAP  = (GAP > 0);
  localparam logic [LEN_W-1:0]   LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0]   LEN_TWO  = LEN_W'(2);
  localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_LEN);

  seq_state_e         r_state;
  logic               r_out_valid;
  logic               r_done;
  logic               r_busy;
  logic               r_pat_ready;
  logic               r_rep_pend;
  logic [GAP_W-1:0]   r_gap_cnt;

  logic [LEN_W-1:0]   w_clamp_len;
  logic [MAX_LEN-1:0] w_align_data;
  logic [MAX_LEN-1:0] w_rep_data;
  logic [LEN_W-1:0]   w_rep_len;
  logic               w_rep_en;
  logic               w_load;
  logic               w_shift;
  logic [MAX_LEN-1:0] w_ld_data;
  logic [LEN_W-1:0]   w_ld_len;
  logic               w_msb;
  logic               w_last;
  logic [LEN_W-1:0]   w_count;

  assign w_clamp_len  = LEN_W'(clamp_len(32'(pat_len), 32'(MAX_LEN)));
  // Left-align so bit pat_len-1 lands in the register MSB.
  assign w_align_data = pat_data << (LEN_MAX - w_clamp_len);

`ifdef SEQ_GEN_REPEAT_EN
  logic [MAX_LEN-1:0] r_shadow_data;
  logic [LEN_W-1:0]   r_shadow_len;

  // Shadow copy of the accepted frame, replayed while rep_en is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow_data <= {MAX_LEN{1'b0}};
      r_shadow_len  <= {LEN_W{1'b0}};
    end else if ((r_state == ST_IDLE) && pat_valid) begin
      r_shadow_data <= w_align_data;
      r_shadow_len  <= w_clamp_len;
    end else begin
      r_shadow_data <= r_shadow_data;
      r_shadow_len  <= r_shadow_len;
    end
  end

  assign w_rep_data = r_shadow_data;
  assign w_rep_len  = r_shadow_len;
  assign w_rep_en   = rep_en;
`else
  assign w_rep_data = {MAX_LEN{1'b0}};
  assign w_rep_len  = {LEN_W{1'b0}};
  assign w_rep_en   = 1'b0;
`endif

  // Shift-register load/shift control derived from the current state.
  always_comb begin
    w_load    = 1'b0;
    w_shift   = 1'b0;
    w_ld_data = w_align_data;
    w_ld_len  = w_clamp_len;
    case (r_state)
      ST_IDLE: begin
        if (pat_valid) begin
          w_load = 1'b1;
        end else begin
          w_load = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (w_last && w_rep_en && !HAS_GAP) begin
          w_load    = 1'b1;
          w_ld_data = w_rep_data;
          w_ld_len  = w_rep_len;
        end else begin
          w_shift = 1'b1;
        end
      end
      ST_GAP: begin
        if ((r_gap_cnt == {GAP_W{1'b0}}) && r_rep_pend) begin
          w_load    = 1'b1;
          w_ld_data = w_rep_data;
          w_ld_len  = w_rep_len;
        end else begin
          w_load = 1'b0;
        end
      end
      default: begin
        w_load  = 1'b0;
        w_shift = 1'b0;
      end
    endcase
  end

  seq_gen_shreg #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .load      (w_load),
    .shift     (w_shift),
    .load_data (w_ld_data),
    .load_len  (w_ld_len),
    .msb       (w_msb),
    .last      (w_last),
    .count     (w_count)
  );

  // Frame FSM; strobes are registered to describe the cycle after each edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_pat_ready <= 1'b1;
      r_rep_pend  <= 1'b0;
      r_gap_cnt   <= {GAP_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (pat_valid) begin
            r_state     <= ST_SHIFT;
            r_out_valid <= 1'b1;
            r_done      <= (w_clamp_len == LEN_ONE);
            r_busy      <= 1'b1;
            r_pat_ready <= 1'b0;
          end else begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_pat_ready <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (!w_last) begin
            r_state     <= ST_SHIFT;
            r_out_valid <= 1'b1;
            r_done      <= (w_count == LEN_TWO);
          end else if (w_rep_en && !HAS_GAP) begin
            r_state     <= ST_SHIFT;
            r_out_valid <= 1'b1;
            r_done      <= (w_rep_len == LEN_ONE);
          end else if (HAS_GAP) begin
            r_state     <= ST_GAP;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_gap_cnt   <= GAP_LAST;
            r_rep_pend  <= w_rep_en;
          end else begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_pat_ready <= 1'b1;
          end
        end
        ST_GAP: begin
          if (r_gap_cnt != {GAP_W{1'b0}}) begin
            r_gap_cnt <= r_gap_cnt - GAP_W'(1);
          end else if (r_rep_pend) begin
            r_state     <= ST_SHIFT;
            r_out_valid <= 1'b1;
            r_done      <= (w_rep_len == LEN_ONE);
            r_rep_pend  <= 1'b0;
          end else begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_pat_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
          r_pat_ready <= 1'b1;
          r_rep_pend  <= 1'b0;
          r_gap_cnt   <= {GAP_W{1'b0}};
        end
      endcase
    end
  end

  assign out       = w_msb;
  assign out_valid = r_out_valid;
  assign done      = r_done;
  assign busy      = r_busy;
  assign pat_ready = r_pat_ready;

endmodule

// File: tb/tb_sequence_gen.sv
// Directed bench for sequence_gen: one instance with GAP=0 and one with GAP=3.
module tb_sequence_gen;

  logic       clk;
  logic       rst;
  logic [7:0] pat_data;
  logic [3:0] pat_len;
  logic       pv0, pv3;
  logic       rdy0, out0, ov0, done0, busy0;
  logic       rdy3, out3, ov3, done3, busy3;
`ifdef SEQ_GEN_REPEAT_EN
  logic       rep_en;
`endif

  int n_checks = 0;
  int n_errors = 0;

  sequence_gen #(.MAX_LEN(8), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .pat_data(pat_data), .pat_len(pat_len), .pat_valid(pv0),
    .pat_ready(rdy0), .out(out0), .out_valid(ov0), .done(done0), .busy(busy0)
`ifdef SEQ_GEN_REPEAT_EN
    , .rep_en(rep_en)
`endif
  );

  sequence_gen #(.MAX_LEN(8), .GAP(3)) u_dut3 (
    .clk(clk), .rst(rst), .pat_data(pat_data), .pat_len(pat_len), .pat_valid(pv3),
    .pat_ready(rdy3), .out(out3), .out_valid(ov3), .done(done3), .busy(busy3)
`ifdef SEQ_GEN_REPEAT_EN
    , .rep_en(rep_en)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input bit g, output logic o, output logic ov, output logic dn,
                        output logic bz, output logic rd);
    if (g) begin
      o = out3; ov = ov3; dn = done3; bz = busy3; rd = rdy3;
    end else begin
      o = out0; ov = ov0; dn = done0; bz = busy0; rd = rdy0;
    end
  endtask

  task automatic set_valid(input bit g, input logic v);
    if (g) pv3 = v;
    else   pv0 = v;
  endtask

  task automatic run_frame(input string tag, input bit g, input logic [7:0] d, input logic [3:0] len,
                           input int n_bits, input logic [7:0] exp_bits, input int gap);
    logic o, ov, dn, bz, rd;
    sample(g, o, ov, dn, bz, rd);
    check_eq({tag, "_ready_pre"}, 32'(rd), 32'd1);
    pat_data = d;
    pat_len  = len;
    set_valid(g, 1'b1);
    tick();
    set_valid(g, 1'b0);
    for (int i = 0; i < n_bits; i++) begin
      sample(g, o, ov, dn, bz, rd);
      check_eq($sformatf("%s_out%0d", tag, i), 32'(o), 32'(exp_bits[n_bits-1-i]));
      check_eq($sformatf("%s_ov%0d", tag, i), 32'(ov), 32'd1);
      check_eq($sformatf("%s_done%0d", tag, i), 32'(dn), 32'(i == n_bits - 1));
      check_eq($sformatf("%s_busy%0d", tag, i), 32'(bz), 32'd1);
      check_eq($sformatf("%s_rdy%0d", tag, i), 32'(rd), 32'd0);
      tick();
    end
    for (int j = 0; j < gap; j++) begin
      sample(g, o, ov, dn, bz, rd);
      check_eq($sformatf("%s_gap_ov%0d", tag, j), 32'(ov), 32'd0);
      check_eq($sformatf("%s_gap_out%0d", tag, j), 32'(o), 32'd0);
      check_eq($sformatf("%s_gap_busy%0d", tag, j), 32'(bz), 32'd1);
      check_eq($sformatf("%s_gap_rdy%0d", tag, j), 32'(rd), 32'd0);
      tick();
    end
    sample(g, o, ov, dn, bz, rd);
    check_eq({tag, "_ready_post"}, 32'(rd), 32'd1);
    check_eq({tag, "_busy_post"}, 32'(bz), 32'd0);
    check_eq({tag, "_ov_post"}, 32'(ov), 32'd0);
  endtask

  initial begin
    logic o, ov, dn, bz, rd;
    logic [3:0] rp;
    rst = 1'b1;
    pat_data = 8'h00;
    pat_len = 4'd0;
    pv0 = 1'b0;
    pv3 = 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
    rep_en = 1'b0;
`endif
    #3;
    sample(1'b0, o, ov, dn, bz, rd);
    check_eq("rst_out", 32'(o), 32'd0);
    check_eq("rst_ov", 32'(ov), 32'd0);
    check_eq("rst_done", 32'(dn), 32'd0);
    check_eq("rst_busy", 32'(bz), 32'd0);
    check_eq("rst_ready", 32'(rd), 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_frame("basic", 1'b0, 8'h0B, 4'd4, 4, 8'b0000_1011, 0);
    run_frame("gap", 1'b1, 8'h02, 4'd2, 2, 8'b0000_0010, 3);
    run_frame("clamp0", 1'b0, 8'hA5, 4'd0, 8, 8'hA5, 0);
    run_frame("clamp15", 1'b0, 8'hA5, 4'd15, 8, 8'hA5, 0);
    run_frame("len1", 1'b1, 8'h01, 4'd1, 1, 8'b0000_0001, 3);

    // Reset in the third bit cycle abandons the frame.
    pat_data = 8'h0B;
    pat_len = 4'd4;
    pv0 = 1'b1;
    tick();
    pv0 = 1'b0;
    check_eq("mrst_b0", 32'(out0), 32'd1);
    tick();
    check_eq("mrst_b1", 32'(out0), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    check_eq("mrst_out", 32'(out0), 32'd0);
    check_eq("mrst_ov", 32'(ov0), 32'd0);
    check_eq("mrst_done", 32'(done0), 32'd0);
    check_eq("mrst_ready", 32'(rdy0), 32'd1);
    check_eq("mrst_busy", 32'(busy0), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("mrst_done_after", 32'(done0), 32'd0);
    run_frame("post_rst", 1'b0, 8'h06, 4'd3, 3, 8'b0000_0110, 0);

    // pat_valid held with new data through a frame: first frame unaltered, second captured after.
    pat_data = 8'h0B;
    pat_len = 4'd4;
    pv0 = 1'b1;
    tick();
    pat_data = 8'h05;
    pat_len = 4'd3;
    rp = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("busy_ld_out%0d", i), 32'(out0), 32'(rp[3-i]));
      check_eq($sformatf("busy_ld_done%0d", i), 32'(done0), 32'(i == 3));
      check_eq($sformatf("busy_ld_rdy%0d", i), 32'(rdy0), 32'd0);
      tick();
    end
    check_eq("busy_ld_ready", 32'(rdy0), 32'd1);
    check_eq("busy_ld_ov", 32'(ov0), 32'd0);
    tick();
    pv0 = 1'b0;
    rp = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("busy_ld2_out%0d", i), 32'(out0), 32'(rp[2-i]));
      check_eq($sformatf("busy_ld2_ov%0d", i), 32'(ov0), 32'd1);
      check_eq($sformatf("busy_ld2_done%0d", i), 32'(done0), 32'(i == 2));
      tick();
    end
    check_eq("busy_ld2_ready", 32'(rdy0), 32'd1);

`ifdef SEQ_GEN_REPEAT_EN
    rep_en = 1'b1;
    pat_data = 8'h0B;
    pat_len = 4'd4;
    pv0 = 1'b1;
    tick();
    pv0 = 1'b0;
    rp = 4'b1011;
    for (int i = 0; i < 12; i++) begin
      check_eq($sformatf("rep_out%0d", i), 32'(out0), 32'(rp[3-(i%4)]));
      check_eq($sformatf("rep_ov%0d", i), 32'(ov0), 32'd1);
      check_eq($sformatf("rep_done%0d", i), 32'(done0), 32'((i % 4) == 3));
      check_eq($sformatf("rep_rdy%0d", i), 32'(rdy0), 32'd0);
      if (i == 8) rep_en = 1'b0;
      tick();
    end
    check_eq("rep_end_ov", 32'(ov0), 32'd0);
    check_eq("rep_end_ready", 32'(rdy0), 32'd1);
    check_eq("rep_end_done", 32'(done0), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
